// File: rtl/dmi_abscmd_seq_pkg.sv
// Types, cmderr codes, register struct and abstract-command field decoder
// for the abstract-command sequencer.
package dmi_abscmd_seq_pkg;
    import river_cfg_pkg::*;
    import types_river_pkg::*;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REG_REQ,
        ST_REG_RESP,
        ST_EXEC_REQ,
        ST_EXEC_RESP,
        ST_MEM_REQ,
        ST_MEM_RESP,
        ST_DONE
    } state_e;

    localparam logic [2:0] CMDERR_NONE    = 3'd0;
    localparam logic [2:0] CMDERR_BUSY    = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUPP = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPT  = 3'd3;
    localparam logic [2:0] CMDERR_BUS     = 3'd5;

    localparam logic [7:0] CMDTYPE_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_MEM = 8'd2;

    // Register and memory commands share bit positions for size, postinc and write.
    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        virt;
        logic [2:0]  size;
        logic        postinc;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } cmd_fields_t;

    typedef struct packed {
        state_e                      state;
        logic [31:0]                 command;
        logic [RISCV_ARCH-1:0]       arg0;
        logic [RISCV_ARCH-1:0]       arg1;
        logic [CFG_LOG2_CPU_MAX-1:0] hartsel;
        logic                        cmd_ready;
        logic                        busy;
        logic                        done;
        logic [2:0]                  cmderr;
        logic [RISCV_ARCH-1:0]       rdata;
        logic                        postinc;
        logic [15:0]                 regno_next;
        logic [RISCV_ARCH-1:0]       arg1_next;
        logic                        req_valid;
        logic [DPortReq_Total-1:0]   dport_type;
        logic [RISCV_ARCH-1:0]       dport_addr;
        logic [2:0]                  dport_size;
        logic                        resp_ready;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:      ST_IDLE,
        command:    '0,
        arg0:       '0,
        arg1:       '0,
        hartsel:    '0,
        cmd_ready:  1'b1,
        busy:       1'b0,
        done:       1'b0,
        cmderr:     CMDERR_NONE,
        rdata:      '0,
        postinc:    1'b0,
        regno_next: '0,
        arg1_next:  '0,
        req_valid:  1'b0,
        dport_type: '0,
        dport_addr: '0,
        dport_size: '0,
        resp_ready: 1'b0
    };

    function automatic cmd_fields_t decode_cmd(input logic [31:0] cmd);
        cmd_fields_t f;
        f.cmdtype  = cmd[31:24];
        f.virt     = cmd[23];
        f.size     = cmd[22:20];
        f.postinc  = cmd[19];
        f.postexec = cmd[18];
        f.transfer = cmd[17];
        f.write    = cmd[16];
        f.regno    = cmd[15:0];
        return f;
    endfunction

    function automatic logic [RISCV_ARCH-1:0] mask_to_size(input logic [RISCV_ARCH-1:0] d,
                                                          input logic [2:0] size);
        logic [RISCV_ARCH-1:0] m;
        case (size)
            3'd0:    m = {{(RISCV_ARCH-8){1'b0}},  d[7:0]};
            3'd1:    m = {{(RISCV_ARCH-16){1'b0}}, d[15:0]};
            3'd2:    m = {{(RISCV_ARCH-32){1'b0}}, d[31:0]};
            default: m = d;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/river_cfg_pkg.sv
// Core configuration constants shared across the River debug blocks.
package river_cfg_pkg;
    localparam int RISCV_ARCH       = 64;
    localparam int CFG_LOG2_CPU_MAX = 1;
endpackage

// File: rtl/types_river_pkg.sv
// Debug-port request type bit indices used by the dport interconnect.
package types_river_pkg;
    localparam int DPortReq_Write      = 0;
    localparam int DPortReq_RegAccess  = 1;
    localparam int DPortReq_MemAccess  = 2;
    localparam int DPortReq_MemVirtual = 3;
    localparam int DPortReq_Progexec   = 4;
    localparam int DPortReq_Total      = 5;
endpackage

// File: rtl/dmi_abscmd_seq.sv
// Abstract-command sequencer: validates one debug abstract command, issues
// the dport transactions it needs and reports completion to the DMI.
module dmi_abscmd_seq
    import river_cfg_pkg::*;
    import types_river_pkg::*;
    import dmi_abscmd_seq_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_nrst,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [31:0]                 i_command,
    input  logic [RISCV_ARCH-1:0]       i_arg0,
    input  logic [RISCV_ARCH-1:0]       i_arg1,
    input  logic [CFG_LOG2_CPU_MAX-1:0] i_hartsel,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [2:0]                  o_cmderr,
    output logic [RISCV_ARCH-1:0]       o_rdata,
    output logic                        o_postinc,
    output logic [15:0]                 o_regno_next,
    output logic [RISCV_ARCH-1:0]       o_arg1_next,
    output logic                        o_dport_req_valid,
    input  logic                        i_dport_req_ready,
    output logic [CFG_LOG2_CPU_MAX-1:0] o_dport_hartsel,
    output logic [DPortReq_Total-1:0]   o_dport_type,
    output logic [RISCV_ARCH-1:0]       o_dport_addr,
    output logic [RISCV_ARCH-1:0]       o_dport_wdata,
    output logic [2:0]                  o_dport_size,
    input  logic                        i_dport_resp_valid,
    output logic                        o_dport_resp_ready,
    input  logic                        i_dport_resp_error,
    input  logic [RISCV_ARCH-1:0]       i_dport_rdata
);

    regs_t                     r;
    cmd_fields_t               w_fld;
    logic                      w_to_done;
    logic [2:0]                w_err;
    logic [DPortReq_Total-1:0] w_type_reg;
    logic [DPortReq_Total-1:0] w_type_mem;
    logic [DPortReq_Total-1:0] w_type_exec;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no
        // path leaves it unassigned (which would infer a latch); use = here, <= only in always_ff.
        w_fld       = decode_cmd(r.command);
        w_to_done   = 1'b0;
        w_err       = CMDERR_NONE;
        w_type_reg  = '0;
        w_type_mem  = '0;
        w_type_exec = '0;

        w_type_reg[DPortReq_Write]     = w_fld.write;
        w_type_reg[DPortReq_RegAccess] = 1'b1;
        w_type_mem[DPortReq_Write]     = w_fld.write;
        if (w_fld.virt) begin
            w_type_mem[DPortReq_MemVirtual] = 1'b1;
        end else begin
            w_type_mem[DPortReq_MemAccess] = 1'b1;
        end
        w_type_exec[DPortReq_Progexec] = 1'b1;

        case (r.state)
            ST_CHECK: begin
                if (w_fld.cmdtype == CMDTYPE_REG) begin
                    if (w_fld.transfer && !(w_fld.size inside {3'd2, 3'd3})) begin
                        w_to_done = 1'b1;
                        w_err     = CMDERR_NOTSUPP;
                    end else if (!w_fld.transfer && !w_fld.postexec) begin
                        w_to_done = 1'b1;
                    end
                end else if (w_fld.cmdtype == CMDTYPE_MEM) begin
                    if (w_fld.size > 3'd3) begin
                        w_to_done = 1'b1;
                        w_err     = CMDERR_NOTSUPP;
                    end
                end else begin
                    w_to_done = 1'b1;
                    w_err     = CMDERR_NOTSUPP;
                end
            end
            ST_REG_RESP: begin
                if (i_dport_resp_valid) begin
                    if (i_dport_resp_error) begin
                        w_to_done = 1'b1;
                        w_err     = CMDERR_EXCEPT;
                    end else if (!w_fld.postexec) begin
                        w_to_done = 1'b1;
                    end
                end
            end
            ST_EXEC_RESP: begin
                if (i_dport_resp_valid) begin
                    w_to_done = 1'b1;
                    w_err     = i_dport_resp_error ? CMDERR_EXCEPT : CMDERR_NONE;
                end
            end
            ST_MEM_RESP: begin
                if (i_dport_resp_valid) begin
                    w_to_done = 1'b1;
                    w_err     = i_dport_resp_error ? CMDERR_BUS : CMDERR_NONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r <= REGS_RESET;
        end else begin
            r.done    <= 1'b0;
            r.postinc <= 1'b0;
            case (r.state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r.state      <= ST_CHECK;
                        r.command    <= i_command;
                        r.arg0       <= i_arg0;
                        r.arg1       <= i_arg1;
                        r.hartsel    <= i_hartsel;
                        r.cmd_ready  <= 1'b0;
                        r.busy       <= 1'b1;
                        r.cmderr     <= CMDERR_NONE;
                        r.rdata      <= '0;
                        r.regno_next <= i_command[15:0] + 16'd1;
                        r.arg1_next  <= i_arg1 + (64'd1 << i_command[22:20]);
                    end
                end
                ST_CHECK: begin
                    if (!w_to_done) begin
                        r.req_valid  <= 1'b1;
                        r.dport_size <= w_fld.size;
                        if (w_fld.cmdtype == CMDTYPE_REG && w_fld.transfer) begin
                            r.state      <= ST_REG_REQ;
                            r.dport_type <= w_type_reg;
                            r.dport_addr <= {{(RISCV_ARCH-16){1'b0}}, w_fld.regno};
                        end else if (w_fld.cmdtype == CMDTYPE_REG) begin
                            r.state      <= ST_EXEC_REQ;
                            r.dport_type <= w_type_exec;
                            r.dport_addr <= '0;
                        end else begin
                            r.state      <= ST_MEM_REQ;
                            r.dport_type <= w_type_mem;
                            r.dport_addr <= r.arg1;
                        end
                    end
                end
                ST_REG_REQ: begin
                    if (i_dport_req_ready) begin
                        r.req_valid  <= 1'b0;
                        r.resp_ready <= 1'b1;
                        r.state      <= ST_REG_RESP;
                    end
                end
                ST_EXEC_REQ: begin
                    if (i_dport_req_ready) begin
                        r.req_valid  <= 1'b0;
                        r.resp_ready <= 1'b1;
                        r.state      <= ST_EXEC_RESP;
                    end
                end
                ST_MEM_REQ: begin
                    if (i_dport_req_ready) begin
                        r.req_valid  <= 1'b0;
                        r.resp_ready <= 1'b1;
                        r.state      <= ST_MEM_RESP;
                    end
                end
                ST_REG_RESP: begin
                    if (i_dport_resp_valid) begin
                        r.rdata      <= mask_to_size(i_dport_rdata, w_fld.size);
                        r.resp_ready <= 1'b0;
                        if (!w_to_done) begin
                            r.state      <= ST_EXEC_REQ;
                            r.req_valid  <= 1'b1;
                            r.dport_type <= w_type_exec;
                            r.dport_addr <= '0;
                        end
                    end
                end
                ST_EXEC_RESP, ST_MEM_RESP: begin
                    if (i_dport_resp_valid) begin
                        r.rdata      <= mask_to_size(i_dport_rdata, w_fld.size);
                        r.resp_ready <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r.state     <= ST_IDLE;
                    r.busy      <= 1'b0;
                    r.cmd_ready <= 1'b1;
                end
                default: r <= REGS_RESET;
            endcase

            // NOTE: the last non-blocking assignment wins, so this overrides the
            // per-state next state whenever the command finishes this cycle.
            if (w_to_done) begin
                r.state   <= ST_DONE;
                r.done    <= 1'b1;
                r.cmderr  <= w_err;
                r.postinc <= w_fld.postinc && (w_err == CMDERR_NONE);
            end
        end
    end

    assign o_cmd_ready        = r.cmd_ready;
    assign o_busy             = r.busy;
    assign o_done             = r.done;
    assign o_cmderr           = r.cmderr;
    assign o_rdata            = r.rdata;
    assign o_postinc          = r.postinc;
    assign o_regno_next       = r.regno_next;
    assign o_arg1_next        = r.arg1_next;
    assign o_dport_req_valid  = r.req_valid;
    assign o_dport_hartsel    = r.hartsel;
    assign o_dport_type       = r.dport_type;
    assign o_dport_addr       = r.dport_addr;
    assign o_dport_wdata      = r.arg0;
    assign o_dport_size       = r.dport_size;
    assign o_dport_resp_ready = r.resp_ready;

endmodule

// File: tb/tb_dmi_abscmd_seq.sv
// Directed bench for dmi_abscmd_seq with a scoreboard of expected dport
// requests and completions.
module tb_dmi_abscmd_seq;
    import river_cfg_pkg::*;
    import types_river_pkg::*;

    localparam int HW = CFG_LOG2_CPU_MAX;
    localparam int TW = DPortReq_Total;
    localparam logic [TW-1:0] ONE    = TW'(1);
    localparam logic [TW-1:0] T_WR   = ONE << DPortReq_Write;
    localparam logic [TW-1:0] T_REG  = ONE << DPortReq_RegAccess;
    localparam logic [TW-1:0] T_MEM  = ONE << DPortReq_MemAccess;
    localparam logic [TW-1:0] T_VIRT = ONE << DPortReq_MemVirtual;
    localparam logic [TW-1:0] T_EXEC = ONE << DPortReq_Progexec;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [31:0]   i_command = '0;
    logic [63:0]   i_arg0 = '0;
    logic [63:0]   i_arg1 = '0;
    logic [HW-1:0] i_hartsel = '0;
    logic          o_busy, o_done, o_postinc;
    logic [2:0]    o_cmderr;
    logic [63:0]   o_rdata, o_arg1_next;
    logic [15:0]   o_regno_next;
    logic          o_dport_req_valid;
    logic          i_dport_req_ready = 1'b0;
    logic [HW-1:0] o_dport_hartsel;
    logic [TW-1:0] o_dport_type;
    logic [63:0]   o_dport_addr, o_dport_wdata;
    logic [2:0]    o_dport_size;
    logic          i_dport_resp_valid = 1'b0;
    logic          o_dport_resp_ready;
    logic          i_dport_resp_error = 1'b0;
    logic [63:0]   i_dport_rdata = '0;

    dmi_abscmd_seq dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_command(i_command), .i_arg0(i_arg0), .i_arg1(i_arg1), .i_hartsel(i_hartsel),
        .o_busy(o_busy), .o_done(o_done), .o_cmderr(o_cmderr), .o_rdata(o_rdata),
        .o_postinc(o_postinc), .o_regno_next(o_regno_next), .o_arg1_next(o_arg1_next),
        .o_dport_req_valid(o_dport_req_valid), .i_dport_req_ready(i_dport_req_ready),
        .o_dport_hartsel(o_dport_hartsel), .o_dport_type(o_dport_type),
        .o_dport_addr(o_dport_addr), .o_dport_wdata(o_dport_wdata), .o_dport_size(o_dport_size),
        .i_dport_resp_valid(i_dport_resp_valid), .o_dport_resp_ready(o_dport_resp_ready),
        .i_dport_resp_error(i_dport_resp_error), .i_dport_rdata(i_dport_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] typ;
        logic [63:0]   addr;
        logic [2:0]    size;
        logic [HW-1:0] hart;
        logic          chk_addr;
        logic [63:0]   wdata;
        logic          chk_wdata;
    } exp_req_t;

    typedef struct {
        logic [2:0]  cmderr;
        logic [63:0] rdata;
        logic        postinc;
        logic [15:0] regno_next;
        logic        chk_regno;
        logic [63:0] arg1_next;
        logic        chk_arg1;
    } exp_done_t;

    exp_req_t  req_q[$];
    exp_done_t done_q[$];
    exp_req_t  m_req;
    exp_done_t m_done;
    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [TW-1:0] typ, input logic [63:0] addr,
                            input logic [2:0] size, input logic [HW-1:0] hart,
                            input logic chk_addr, input logic [63:0] wdata, input logic chk_wdata);
        exp_req_t e;
        e.typ = typ; e.addr = addr; e.size = size; e.hart = hart;
        e.chk_addr = chk_addr; e.wdata = wdata; e.chk_wdata = chk_wdata;
        req_q.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] err, input logic [63:0] rdata, input logic postinc,
                             input logic [15:0] regno_next, input logic chk_regno,
                             input logic [63:0] arg1_next, input logic chk_arg1);
        exp_done_t e;
        e.cmderr = err; e.rdata = rdata; e.postinc = postinc;
        e.regno_next = regno_next; e.chk_regno = chk_regno;
        e.arg1_next = arg1_next; e.chk_arg1 = chk_arg1;
        done_q.push_back(e);
    endtask

    // Scoreboard side: compare each request handshake and each completion.
    always @(negedge clk) begin
        if (nrst) begin
            if (o_dport_req_valid && i_dport_req_ready) begin
                n_req++;
                if (req_q.size() == 0) begin
                    check("unexpected_req", 64'(o_dport_req_valid), 64'd0);
                end else begin
                    m_req = req_q.pop_front();
                    check("req_type", 64'(o_dport_type), 64'(m_req.typ));
                    check("req_hartsel", 64'(o_dport_hartsel), 64'(m_req.hart));
                    if (m_req.chk_addr) begin
                        check("req_addr", o_dport_addr, m_req.addr);
                        check("req_size", 64'(o_dport_size), 64'(m_req.size));
                    end
                    if (m_req.chk_wdata) check("req_wdata", o_dport_wdata, m_req.wdata);
                end
            end
            if (o_done) begin
                n_done++;
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(o_done), 64'd0);
                end else begin
                    m_done = done_q.pop_front();
                    check("done_cmderr", 64'(o_cmderr), 64'(m_done.cmderr));
                    check("done_rdata", o_rdata, m_done.rdata);
                    check("done_postinc", 64'(o_postinc), 64'(m_done.postinc));
                    if (m_done.chk_regno) check("done_regno_next", 64'(o_regno_next), 64'(m_done.regno_next));
                    if (m_done.chk_arg1) check("done_arg1_next", o_arg1_next, m_done.arg1_next);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] cmd, input logic [63:0] a0, input logic [63:0] a1,
                            input logic [HW-1:0] hart);
        int t = 0;
        while (!o_cmd_ready && t < 20) begin tick(); t++; end
        check("cmd_ready_before_send", 64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b1; i_command = cmd; i_arg0 = a0; i_arg1 = a1; i_hartsel = hart;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic accept_req();
        int t = 0;
        while (!o_dport_req_valid && t < 20) begin tick(); t++; end
        check("req_valid_wait", 64'(o_dport_req_valid), 64'd1);
        i_dport_req_ready = 1'b1;
        tick();
        i_dport_req_ready = 1'b0;
    endtask

    task automatic give_resp(input logic [63:0] data, input logic err);
        check("resp_ready", 64'(o_dport_resp_ready), 64'd1);
        i_dport_resp_valid = 1'b1; i_dport_rdata = data; i_dport_resp_error = err;
        tick();
        i_dport_resp_valid = 1'b0; i_dport_rdata = '0; i_dport_resp_error = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!o_done && t < 20) begin tick(); t++; end
        check("done_wait", 64'(o_done), 64'd1);
        tick();
        check("cmd_ready_after_done", 64'(o_cmd_ready), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_cmderr"}, 64'(o_cmderr), 64'd0);
        check({tag, "_rdata"}, o_rdata, 64'd0);
        check({tag, "_postinc"}, 64'(o_postinc), 64'd0);
        check({tag, "_regno_next"}, 64'(o_regno_next), 64'd0);
        check({tag, "_arg1_next"}, o_arg1_next, 64'd0);
        check({tag, "_req_valid"}, 64'(o_dport_req_valid), 64'd0);
        check({tag, "_hartsel"}, 64'(o_dport_hartsel), 64'd0);
        check({tag, "_type"}, 64'(o_dport_type), 64'd0);
        check({tag, "_addr"}, o_dport_addr, 64'd0);
        check({tag, "_wdata"}, o_dport_wdata, 64'd0);
        check({tag, "_size"}, 64'(o_dport_size), 64'd0);
        check({tag, "_resp_ready"}, 64'(o_dport_resp_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_before;
        int done_before;

        // Reset state
        tick(); tick();
        check_idle_outputs("rst_init");
        nrst = 1'b1;
        tick();

        // Register read with latency checks
        push_req(T_REG, 64'h1008, 3'd3, HW'(1), 1'b1, 64'd0, 1'b0);
        push_done(3'd0, 64'h1234, 1'b0, 16'h1009, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0032_1008, 64'hAAAA, 64'h0, HW'(1));
        check("t1_busy_after_accept", 64'(o_busy), 64'd1);
        check("t1_ready_after_accept", 64'(o_cmd_ready), 64'd0);
        check("t1_no_req_in_check", 64'(o_dport_req_valid), 64'd0);
        tick();
        check("t1_req_at_n2", 64'(o_dport_req_valid), 64'd1);
        accept_req();
        give_resp(64'h1234, 1'b0);
        check("t1_done_at_n4", 64'(o_done), 64'd1);
        wait_done();

        // Write + postexec, error on register access skips Progexec
        req_before = n_req;
        push_req(T_REG | T_WR, 64'h0300, 3'd3, HW'(0), 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        push_done(3'd3, 64'd0, 1'b0, 16'h0301, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0037_0300, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, HW'(0));
        accept_req();
        give_resp(64'd0, 1'b1);
        wait_done();
        check("t2_err_req_count", 64'(n_req - req_before), 64'd1);

        // Write + postexec, both transactions succeed
        req_before = n_req;
        push_req(T_REG | T_WR, 64'h0300, 3'd3, HW'(1), 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        push_req(T_EXEC, 64'd0, 3'd0, HW'(1), 1'b0, 64'd0, 1'b0);
        push_done(3'd0, 64'd0, 1'b0, 16'h0301, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0037_0300, 64'h0123_4567_89AB_CDEF, 64'h0, HW'(1));
        accept_req();
        give_resp(64'd0, 1'b0);
        accept_req();
        give_resp(64'd0, 1'b0);
        wait_done();
        check("t2b_req_count", 64'(n_req - req_before), 64'd2);

        // Register command with neither transfer nor postexec
        req_before = n_req;
        push_done(3'd0, 64'd0, 1'b0, 16'h0001, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0030_0000, 64'h0, 64'h0, HW'(0));
        wait_done();
        check("t2c_req_count", 64'(n_req - req_before), 64'd0);

        // Memory post-increment read wrapping the address
        push_req(T_MEM, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, HW'(0), 1'b1, 64'd0, 1'b0);
        push_done(3'd0, 64'h5566_7788, 1'b1, 16'd0, 1'b0, 64'd0, 1'b1);
        send_cmd(32'h0228_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, HW'(0));
        accept_req();
        give_resp(64'h1122_3344_5566_7788, 1'b0);
        wait_done();

        // Virtual memory write with bus error
        push_req(T_VIRT | T_WR, 64'h1000, 3'd1, HW'(1), 1'b1, 64'h0102_0304_0506_0708, 1'b1);
        push_done(3'd5, 64'd0, 1'b0, 16'd0, 1'b0, 64'h1002, 1'b1);
        send_cmd(32'h0291_0000, 64'h0102_0304_0506_0708, 64'h1000, HW'(1));
        accept_req();
        give_resp(64'd0, 1'b1);
        wait_done();

        // Unsupported commands issue no dport traffic
        req_before = n_req;
        push_done(3'd2, 64'd0, 1'b0, 16'h1001, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0042_1000, 64'h0, 64'h0, HW'(0));
        wait_done();
        push_done(3'd2, 64'd0, 1'b0, 16'd0, 1'b0, 64'd0, 1'b0);
        send_cmd(32'h0100_0000, 64'h0, 64'h0, HW'(0));
        wait_done();
        push_done(3'd2, 64'd0, 1'b0, 16'd0, 1'b0, 64'd0, 1'b0);
        send_cmd(32'h0248_0000, 64'h0, 64'h0, HW'(0));
        wait_done();
        check("t4_req_count", 64'(n_req - req_before), 64'd0);

        // Backpressure with a new command and hartsel change while busy
        req_before = n_req;
        push_req(T_REG, 64'h1004, 3'd2, HW'(1), 1'b1, 64'd0, 1'b0);
        push_done(3'd0, 64'h8765_4321, 1'b0, 16'h1005, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0022_1004, 64'h55, 64'h0, HW'(1));
        i_hartsel = HW'(0);
        i_cmd_valid = 1'b1;
        i_command = 32'h0032_1008;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", 64'(o_dport_req_valid), 64'd1);
            check("bp_addr", o_dport_addr, 64'h1004);
            check("bp_type", 64'(o_dport_type), 64'(T_REG));
            check("bp_size", 64'(o_dport_size), 64'd2);
            check("bp_hartsel", 64'(o_dport_hartsel), 64'd1);
            check("bp_cmd_ready", 64'(o_cmd_ready), 64'd0);
            tick();
        end
        i_cmd_valid = 1'b0;
        accept_req();
        give_resp(64'hFFFF_FFFF_8765_4321, 1'b0);
        wait_done();
        tick();
        check("bp_idle_busy", 64'(o_busy), 64'd0);
        check("bp_req_count", 64'(n_req - req_before), 64'd1);

        // Reset while waiting for a register response
        push_req(T_REG, 64'h1008, 3'd3, HW'(1), 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0032_1008, 64'h77, 64'h99, HW'(1));
        accept_req();
        check("rst_in_regresp", 64'(o_dport_resp_ready), 64'd1);
        done_before = n_done;
        nrst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        tick(); tick();
        nrst = 1'b1;
        tick(); tick(); tick();
        check("rst_no_done", 64'(n_done - done_before), 64'd0);

        push_req(T_REG, 64'h2000, 3'd3, HW'(0), 1'b1, 64'd0, 1'b0);
        push_done(3'd0, 64'hABCD, 1'b0, 16'h2001, 1'b1, 64'd0, 1'b0);
        send_cmd(32'h0032_2000, 64'h0, 64'h0, HW'(0));
        accept_req();
        give_resp(64'hABCD, 1'b0);
        wait_done();

        tick(); tick();
        check("scoreboard_req_drained", 64'(req_q.size()), 64'd0);
        check("scoreboard_done_drained", 64'(done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
